// File: rtl/avalon_clic_pkg.sv
// Shared constants, state type and byte-lane helper for the CLIC timer slot.
package avalon_clic_pkg;

    localparam logic [15:0] CLIC_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLIC_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLIC_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLIC_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLIC_MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] CLIC_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE,
        DATA
    } clic_rd_state_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] clic_merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/avalon_clic_prescaler.sv
// Free-running divider: tick is high on the last count of each TICK_DIV-cycle period.
module avalon_clic_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/avalon_clic_timer.sv
// CLIC timer slave: mtime/mtimecmp/msip behind a 2-cycle-read Avalon port.
// Optional CLIC_MTIME_SNAPSHOT_EN: mtime_lo reads latch mtime_hi into a shadow returned by mtime_hi reads.
module avalon_clic_timer
    import avalon_clic_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TICK_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            avn_read,
    input  logic            avn_write,
    input  logic [AW-1:0]   avn_address,
    input  logic [DW/8-1:0] avn_byte_enable,
    input  logic [DW-1:0]   avn_writedata,
    output logic [DW-1:0]   avn_readdata,
    output logic            avn_waitrequest,
    output logic            software_interrupt,
    output logic            timer_interrupt
);

    logic [15:0]    offset;
    logic           unused_addr;
    logic           tick;
    logic           msip;
    logic [63:0]    mtime;
    logic [63:0]    mtimecmp;
    logic [63:0]    mtime_base;
    logic [63:0]    mtime_next;
    logic [31:0]    rd_value;
    logic           capture;
    logic           wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;
    clic_rd_state_t state, state_next;

    assign offset      = {avn_address[15:2], 2'b00};
    assign unused_addr = ^{avn_address[AW-1:16], avn_address[1:0]};

    assign wr_msip     = avn_write && (offset == CLIC_MSIP_OFF);
    assign wr_cmp_lo   = avn_write && (offset == CLIC_MTIMECMP_LO_OFF);
    assign wr_cmp_hi   = avn_write && (offset == CLIC_MTIMECMP_HI_OFF);
    assign wr_mtime_lo = avn_write && (offset == CLIC_MTIME_LO_OFF);
    assign wr_mtime_hi = avn_write && (offset == CLIC_MTIME_HI_OFF);

    avalon_clic_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Any mtime write suppresses the increment for the full 64 bits; unwritten lanes keep the pre-tick value.
    always_comb begin
        if (wr_mtime_lo || wr_mtime_hi) begin
            mtime_base = mtime;
        end else if (tick) begin
            mtime_base = mtime + 64'd1;
        end else begin
            mtime_base = mtime;
        end
        mtime_next = mtime_base;
        if (wr_mtime_lo) begin
            mtime_next[31:0] = clic_merge_bytes(mtime[31:0], avn_writedata, avn_byte_enable);
        end
        if (wr_mtime_hi) begin
            mtime_next[63:32] = clic_merge_bytes(mtime[63:32], avn_writedata, avn_byte_enable);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime           <= '0;
            mtimecmp        <= CLIC_MTIMECMP_RST;
            msip            <= 1'b0;
            timer_interrupt <= 1'b0;
        end else begin
            mtime           <= mtime_next;
            timer_interrupt <= (mtime >= mtimecmp);
            if (wr_msip && avn_byte_enable[0]) begin
                msip <= avn_writedata[0];
            end
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= clic_merge_bytes(mtimecmp[31:0], avn_writedata, avn_byte_enable);
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= clic_merge_bytes(mtimecmp[63:32], avn_writedata, avn_byte_enable);
            end
        end
    end

    assign software_interrupt = msip;

`ifdef CLIC_MTIME_SNAPSHOT_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_hi_shadow <= '0;
        end else if (capture && (offset == CLIC_MTIME_LO_OFF)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end
`endif

    always_comb begin
        rd_value = '0;
        case (offset)
            CLIC_MSIP_OFF:        rd_value = {31'd0, msip};
            CLIC_MTIMECMP_LO_OFF: rd_value = mtimecmp[31:0];
            CLIC_MTIMECMP_HI_OFF: rd_value = mtimecmp[63:32];
            CLIC_MTIME_LO_OFF:    rd_value = mtime[31:0];
`ifdef CLIC_MTIME_SNAPSHOT_EN
            CLIC_MTIME_HI_OFF:    rd_value = mtime_hi_shadow;
`else
            CLIC_MTIME_HI_OFF:    rd_value = mtime[63:32];
`endif
            default:              rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A read overlapping a write is dropped; reset forces waitrequest low even mid-read.
    always_comb begin
        state_next      = state;
        avn_waitrequest = 1'b0;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                if (avn_read && !avn_write && !rst) begin
                    avn_waitrequest = 1'b1;
                    capture         = 1'b1;
                    state_next      = DATA;
                end
            end
            DATA: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avn_readdata <= '0;
        end else if (capture) begin
            avn_readdata <= rd_value;
        end
    end

endmodule

// File: tb/tb_avalon_clic_timer.sv
// Directed bench: one instance with TICK_DIV=4 and one with TICK_DIV=1 share the bus inputs.
module tb_avalon_clic_timer;

    localparam logic [15:0] MSIP   = 16'h0000;
    localparam logic [15:0] CMP_LO = 16'h4000;
    localparam logic [15:0] CMP_HI = 16'h4004;
    localparam logic [15:0] MT_LO  = 16'hBFF8;
    localparam logic [15:0] MT_HI  = 16'hBFFC;

    logic        clk, rst;
    logic        avn_read, avn_write;
    logic [31:0] avn_address;
    logic [3:0]  avn_byte_enable;
    logic [31:0] avn_writedata;
    logic [31:0] rd4, rd1;
    logic        wr4, wr1, sw4, sw1, ti4, ti1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    avalon_clic_timer #(.AW(32), .DW(32), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .avn_read(avn_read), .avn_write(avn_write),
        .avn_address(avn_address), .avn_byte_enable(avn_byte_enable),
        .avn_writedata(avn_writedata), .avn_readdata(rd4), .avn_waitrequest(wr4),
        .software_interrupt(sw4), .timer_interrupt(ti4)
    );

    avalon_clic_timer #(.AW(32), .DW(32), .TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .avn_read(avn_read), .avn_write(avn_write),
        .avn_address(avn_address), .avn_byte_enable(avn_byte_enable),
        .avn_writedata(avn_writedata), .avn_readdata(rd1), .avn_waitrequest(wr1),
        .software_interrupt(sw1), .timer_interrupt(ti1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; both prescalers and mtimes follow from this.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; avn_read = 1'b0; avn_write = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    // Called and returns on a falling edge; the write lands on the rising edge in between.
    task automatic bus_write(input logic [15:0] off, input logic [3:0] be, input logic [31:0] d);
        avn_address = {16'h0, off}; avn_byte_enable = be; avn_writedata = d; avn_write = 1'b1;
        @(negedge clk);
        avn_write = 1'b0;
    endtask

    // Read costs two cycles; nwait counts falling edges seen with waitrequest high.
    task automatic bus_read(input logic [15:0] off, output logic [31:0] d4, output logic [31:0] d1,
                            output int nwait);
        avn_address = {16'h0, off}; avn_read = 1'b1; nwait = 0;
        #1;
        while (wr4 === 1'b1 && nwait < 4) begin
            @(negedge clk);
            nwait++;
        end
        d4 = rd4; d1 = rd1;
        avn_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d4, d1; int nw;
        rst = 1'b1; avn_read = 1'b0; avn_write = 1'b0;
        avn_address = '0; avn_byte_enable = '0; avn_writedata = '0;
        @(negedge clk); #1;
        n_checks++; if (wr4 !== 1'b0) begin n_fail++; $display("FAIL rst_wait: got %b expected 0", wr4); end
        n_checks++; if (rd4 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rd4); end
        n_checks++; if (ti4 !== 1'b0) begin n_fail++; $display("FAIL rst_timer: got %b expected 0", ti4); end
        n_checks++; if (sw4 !== 1'b0) begin n_fail++; $display("FAIL rst_sw: got %b expected 0", sw4); end
        @(negedge clk);
        rst = 1'b0;
        bus_read(CMP_LO, d4, d1, nw);
        n_checks++; if (d4 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp_lo: got %h expected ffffffff", d4); end
        bus_read(CMP_HI, d4, d1, nw);
        n_checks++; if (d4 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp_hi: got %h expected ffffffff", d4); end
        bus_read(MSIP, d4, d1, nw);
        n_checks++; if (d4 !== 32'h0) begin n_fail++; $display("FAIL rst_msip: got %h expected 0", d4); end
        n_checks++; if (wr4 !== 1'b0) begin n_fail++; $display("FAIL rst_idle_wait: got %b expected 0", wr4); end
        n_checks++; if (ti4 !== 1'b0) begin n_fail++; $display("FAIL rst_idle_timer: got %b expected 0", ti4); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d4, d1; int nw;
        do_reset();
        repeat (40) @(negedge clk);
        bus_read(MT_LO, d4, d1, nw);
        n_checks++; if (d4 !== 32'd10) begin n_fail++; $display("FAIL presc_lo_div4: got %0d expected 10", d4); end
        n_checks++; if (d1 !== 32'd40) begin n_fail++; $display("FAIL presc_lo_div1: got %0d expected 40", d1); end
        bus_read(MT_HI, d4, d1, nw);
        n_checks++; if (d4 !== 32'd0) begin n_fail++; $display("FAIL presc_hi_div4: got %0d expected 0", d4); end
    endtask

    task automatic test_compare();
        int guard;
        do_reset();
        bus_write(CMP_HI, 4'hF, 32'd0);
        bus_write(CMP_LO, 4'hF, 32'd20);
        guard = 0;
        while (cyc < 20 && guard < 200) begin @(negedge clk); guard++; end
        n_checks++; if (ti1 !== 1'b0) begin n_fail++; $display("FAIL cmp_div1_before: got %b expected 0", ti1); end
        @(negedge clk);
        n_checks++; if (ti1 !== 1'b1) begin n_fail++; $display("FAIL cmp_div1_rise: got %b expected 1", ti1); end
        guard = 0;
        while (cyc < 80 && guard < 200) begin @(negedge clk); guard++; end
        n_checks++; if (ti4 !== 1'b0) begin n_fail++; $display("FAIL cmp_div4_before: got %b expected 0", ti4); end
        @(negedge clk);
        n_checks++; if (ti4 !== 1'b1) begin n_fail++; $display("FAIL cmp_div4_rise: got %b expected 1", ti4); end
        bus_write(CMP_HI, 4'hF, 32'd1);
        n_checks++; if (ti4 !== 1'b1 || ti1 !== 1'b1) begin n_fail++; $display("FAIL cmp_hold: got %b%b expected 11", ti4, ti1); end
        @(negedge clk);
        n_checks++; if (ti4 !== 1'b0 || ti1 !== 1'b0) begin n_fail++; $display("FAIL cmp_fall: got %b%b expected 00", ti4, ti1); end
    endtask

    task automatic test_handshake();
        logic [31:0] d4, d1; int nw;
        bus_read(CMP_LO, d4, d1, nw);
        n_checks++; if (nw !== 1) begin n_fail++; $display("FAIL hs_wait_cycles: got %0d expected 1", nw); end
        n_checks++; if (d4 !== 32'd20) begin n_fail++; $display("FAIL hs_data: got %0d expected 20", d4); end
        bus_read(16'h0100, d4, d1, nw);
        n_checks++; if (d4 !== 32'd0) begin n_fail++; $display("FAIL hs_unmapped: got %h expected 0", d4); end
        bus_write(16'h4008, 4'hF, 32'hDEAD_BEEF);
        bus_read(16'h4008, d4, d1, nw);
        n_checks++; if (d4 !== 32'd0) begin n_fail++; $display("FAIL hs_unmapped_wr: got %h expected 0", d4); end
    endtask

    task automatic test_back_to_back();
        avn_address = {16'h0, CMP_HI}; avn_read = 1'b1;
        #1;
        n_checks++; if (wr4 !== 1'b1) begin n_fail++; $display("FAIL b2b_wait0: got %b expected 1", wr4); end
        @(negedge clk);
        n_checks++; if (wr4 !== 1'b0 || rd4 !== 32'd1) begin n_fail++; $display("FAIL b2b_data0: got %b/%h expected 0/1", wr4, rd4); end
        avn_address = {16'h0, CMP_LO};
        @(negedge clk);
        n_checks++; if (wr4 !== 1'b1) begin n_fail++; $display("FAIL b2b_wait1: got %b expected 1", wr4); end
        @(negedge clk);
        n_checks++; if (wr4 !== 1'b0 || rd4 !== 32'd20) begin n_fail++; $display("FAIL b2b_data1: got %b/%h expected 0/14", wr4, rd4); end
        avn_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lanes();
        logic [31:0] d4, d1; int nw;
        bus_write(MSIP, 4'b0010, 32'h1);
        n_checks++; if (sw4 !== 1'b0) begin n_fail++; $display("FAIL lane_msip_be2: got %b expected 0", sw4); end
        bus_write(MSIP, 4'b0001, 32'h1);
        n_checks++; if (sw4 !== 1'b1) begin n_fail++; $display("FAIL lane_msip_be1: got %b expected 1", sw4); end
        bus_write(MSIP, 4'hF, 32'hFFFF_FFFF);
        bus_read(MSIP, d4, d1, nw);
        n_checks++; if (d4 !== 32'h1) begin n_fail++; $display("FAIL lane_msip_rd: got %h expected 1", d4); end
        avn_address = {16'h0, MSIP}; avn_byte_enable = 4'hF; avn_writedata = 32'h0;
        avn_read = 1'b1; avn_write = 1'b1;
        #1;
        n_checks++; if (wr4 !== 1'b0) begin n_fail++; $display("FAIL rw_wait: got %b expected 0", wr4); end
        @(negedge clk);
        n_checks++; if (wr4 !== 1'b0 || sw4 !== 1'b0) begin n_fail++; $display("FAIL rw_write_wins: got %b/%b expected 0/0", wr4, sw4); end
        avn_read = 1'b0; avn_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] d4, d1; int nw;
        bus_write(MT_LO, 4'hF, 32'hFFFF_FFFF);
        bus_write(MT_HI, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        bus_read(MT_LO, d4, d1, nw);
        n_checks++; if (d1 !== 32'd0) begin n_fail++; $display("FAIL wrap_lo: got %h expected 0", d1); end
        bus_read(MT_HI, d4, d1, nw);
        n_checks++; if (d1 !== 32'd0) begin n_fail++; $display("FAIL wrap_hi: got %h expected 0", d1); end
        bus_write(MT_LO, 4'hF, 32'hFFFF_FFFF);
        bus_write(MT_HI, 4'hF, 32'h0);
        @(negedge clk);
        bus_read(MT_LO, d4, d1, nw);
        n_checks++; if (d1 !== 32'd0) begin n_fail++; $display("FAIL carry_lo: got %h expected 0", d1); end
        bus_read(MT_HI, d4, d1, nw);
        n_checks++; if (d1 !== 32'd1) begin n_fail++; $display("FAIL carry_hi: got %h expected 1", d1); end
    endtask

    task automatic test_collision();
        logic [31:0] d4, d1; int nw;
        bus_write(MT_LO, 4'hF, 32'd5);
        bus_read(MT_LO, d4, d1, nw);
        n_checks++; if (d1 !== 32'd5) begin n_fail++; $display("FAIL coll_lo: got %h expected 5", d1); end
        bus_write(MT_LO, 4'b0001, 32'h1234_56AB);
        bus_read(MT_LO, d4, d1, nw);
        n_checks++; if (d1 !== 32'h0000_00AB) begin n_fail++; $display("FAIL coll_lane: got %h expected 000000ab", d1); end
        bus_read(MT_HI, d4, d1, nw);
        n_checks++; if (d1 !== 32'd1) begin n_fail++; $display("FAIL coll_hi: got %h expected 1", d1); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d4, d1, exp_hi; int nw;
`ifdef CLIC_MTIME_SNAPSHOT_EN
        exp_hi = 32'd1;
`else
        exp_hi = 32'd2;
`endif
        bus_write(MT_HI, 4'hF, 32'd1);
        bus_write(MT_LO, 4'hF, 32'hFFFF_FFFF);
        bus_read(MT_LO, d4, d1, nw);
        n_checks++; if (d1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL snap_lo: got %h expected ffffffff", d1); end
        bus_read(MT_HI, d4, d1, nw);
        n_checks++; if (d1 !== exp_hi) begin n_fail++; $display("FAIL snap_hi: got %h expected %h", d1, exp_hi); end
    endtask

    task automatic test_reset_mid_read();
        bus_write(MSIP, 4'hF, 32'h1);
        avn_address = {16'h0, CMP_LO}; avn_read = 1'b1;
        #1;
        n_checks++; if (wr4 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b expected 1", wr4); end
        rst = 1'b1;
        #1;
        n_checks++; if (wr4 !== 1'b0 || rd4 !== 32'h0 || sw4 !== 1'b0)
            begin n_fail++; $display("FAIL midrst_clear: got %b/%h/%b expected 0/0/0", wr4, rd4, sw4); end
        avn_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        avn_read = 1'b0; avn_write = 1'b0;
        avn_address = '0; avn_byte_enable = '0; avn_writedata = '0;
        @(negedge clk);
        test_reset();
        test_prescaler();
        test_compare();
        test_handshake();
        test_back_to_back();
        test_lanes();
        test_wrap();
        test_collision();
        test_snapshot();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
